// File: rtl/mac_accumulate_stage_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mac_pkg
// Description : Shared types and widths for the MAC accumulate stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    localparam int MAC_WIDTH = 48;
    localparam int MAC_GUARD = 8;
    localparam int PROD_W    = 2 * MAC_WIDTH;
    localparam int ACC_W     = PROD_W + MAC_GUARD;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [ACC_W-1:0] data;
        logic             ovf;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/mac_accumulate_stage_if.sv
`default_nettype none
// ============================================================================
// Interface   : mac_accumulate_stage_if
// Description : Operand handshake, product input and result stream bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_accumulate_stage_if
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH,
    parameter int GUARD = MAC_GUARD
);

    logic                     in_valid;
    logic                     in_ready;
    logic                     in_first;
    logic                     in_last;
    logic [2*WIDTH-1:0]       mul_y;
    logic                     out_valid;
    logic                     out_ready;
    logic [2*WIDTH+GUARD-1:0] out_data;
    logic                     out_ovf;
    logic                     err;

    modport master (
        output in_valid, in_first, in_last, mul_y, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, err
    );

    modport slave (
        input  in_valid, in_first, in_last, mul_y, out_ready,
        output in_ready, out_valid, out_data, out_ovf, err
    );

endinterface
`default_nettype wire

// File: rtl/mac_accumulate_stage_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : result_fifo
// Description : Circular result buffer with extended-pointer full/empty.
// Revision    : 1.0 - initial release
// ============================================================================
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int EW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [EW-1:0]            i_data,
    input  logic                     i_pop,
    output logic [EW-1:0]            o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int IW = $clog2(DEPTH);

    logic [EW-1:0] r_mem [DEPTH];
    logic [IW:0]   r_wptr;
    logic [IW:0]   r_rptr;
    logic          w_pop;

    assign w_pop = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // Writer relies on upstream credit, so a push never meets a full buffer.
            if (i_push) begin
                r_mem[r_wptr[IW-1:0]] <= i_data;
                r_wptr                <= r_wptr + (IW+1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (IW+1)'(1);
            end
        end
    end

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = ((r_wptr ^ r_rptr) == {1'b1, {IW{1'b0}}});
    assign o_count = r_wptr - r_rptr;
    assign o_data  = r_mem[r_rptr[IW-1:0]];

endmodule
`default_nettype wire

// File: rtl/mac_accumulate_stage.sv
`default_nettype none
// ============================================================================
// Module      : mac_accumulate_stage
// Description : Frames multiplier products into guarded dot-product results.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_accumulate_stage
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH,
    parameter int GUARD = MAC_GUARD,
    parameter int LAT   = 3,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mac_accumulate_stage_if.slave bus
);

    localparam int PW = 2 * WIDTH;
    localparam int AW = PW + GUARD;
    localparam int EW = AW + 1;
    localparam int OW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(DEPTH + LAT + 1);

    tag_t          r_tag [LAT];
    tag_t          w_tail;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_acc;
    logic [AW-1:0] w_acc_nxt;
    logic          r_ovf;
    logic          w_ovf_nxt;
    logic          r_err;
    logic          w_err_set;
    logic          w_start;
    logic [AW:0]   w_sum;
    logic [AW-1:0] w_frame_sum;
    logic          w_frame_ovf;
    logic          w_push;
    logic [EW-1:0] w_push_entry;
    logic [EW-1:0] w_head;
    logic          w_full;
    logic          w_empty;
    logic [OW-1:0] w_occ;
    logic [CW-1:0] w_pending;
    logic [CW-1:0] w_space;

    // Tags travel beside the untagged multiplier pipeline; the tail lines up with mul_y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= '{valid: bus.in_valid & bus.in_ready,
                          first: bus.in_first,
                          last:  bus.in_last};
            for (int i = 1; i < LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_tail = r_tag[LAT-1];
    assign w_sum  = {1'b0, r_acc} + {{(GUARD+1){1'b0}}, bus.mul_y};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_ovf   <= w_ovf_nxt;
            r_err   <= r_err | w_err_set;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_ovf_nxt    = r_ovf;
        w_err_set    = 1'b0;
        w_start      = 1'b0;
        w_frame_sum  = '0;
        w_frame_ovf  = 1'b0;
        w_push       = 1'b0;
        w_push_entry = '0;
        if (w_tail.valid) begin
            // A missing first in IDLE or a stray first in RUN both restart the frame here.
            w_start   = (r_state == ST_IDLE) | w_tail.first;
            w_err_set = (r_state == ST_IDLE) ? ~w_tail.first : w_tail.first;
            if (w_start) begin
                w_frame_sum = {{GUARD{1'b0}}, bus.mul_y};
                w_frame_ovf = 1'b0;
            end else begin
                w_frame_sum = w_sum[AW-1:0];
                w_frame_ovf = r_ovf | w_sum[AW];
            end
            w_acc_nxt = w_frame_sum;
            w_ovf_nxt = w_frame_ovf;
            if (w_tail.last) begin
                w_push       = 1'b1;
                w_push_entry = {w_frame_sum, w_frame_ovf};
                w_state_nxt  = ST_IDLE;
            end else begin
                w_state_nxt  = ST_RUN;
            end
        end
    end

    // Every last already in flight has a reserved slot; a pop this cycle earns nothing yet.
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < LAT; i++) begin
            w_pending = w_pending + CW'(r_tag[i].valid & r_tag[i].last);
        end
    end

    assign w_space      = CW'(DEPTH) - CW'(w_occ);
    assign bus.in_ready = ~w_full & (w_space > w_pending);

    result_fifo #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_result_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (bus.out_ready),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_occ)
    );

    assign bus.out_valid = ~w_empty;
    assign bus.out_data  = w_head[EW-1:1];
    assign bus.out_ovf   = w_head[0];
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mac_accumulate_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_accumulate_stage
// Description : Directed bench for mac_accumulate_stage with a 3-stage multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_accumulate_stage;
    import mac_pkg::*;

    localparam int WIDTH = 48;
    localparam int GUARD = 8;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [WIDTH-1:0]   a = '0;
    logic [WIDTH-1:0]   b = '0;
    logic [2*WIDTH-1:0] p0, p1, p2;

    int n_checks = 0;
    int n_fail   = 0;
    int n_stalls = 0;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [ACC_W-1:0] exp;
    } vec_t;

    vec_t             vecs   [6];
    logic [ACC_W-1:0] bp_exp [4];

    mac_accumulate_stage_if #(.WIDTH(WIDTH), .GUARD(GUARD)) bus ();

    mac_accumulate_stage #(
        .WIDTH (WIDTH),
        .GUARD (GUARD),
        .LAT   (LAT),
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Stand-in multiplier: fixed 3-edge latency, no reset, no stall.
    always @(posedge clk) begin
        p0 <= {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        p1 <= p0;
        p2 <= p1;
    end
    assign bus.mul_y = p2;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    // Called #1 after an edge; the transfer happens on the next edge.
    task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic f, input logic l);
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            n_stalls++;
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) timeout("send_in_ready");
        a = av;
        b = bv;
        bus.in_first = f;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_result(input string name, input logic [ACC_W-1:0] exp_d, input logic exp_o);
        int n = 0;
        while (!bus.out_valid && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.out_valid) begin
            timeout(name);
        end else begin
            check($sformatf("%s_data", name), 128'(bus.out_data), 128'(exp_d));
            check($sformatf("%s_ovf", name), 128'(bus.out_ovf), 128'(exp_o));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0;
        int acc_n;
        logic hs;

        vecs[0] = '{48'd3, 48'd5, 104'd15};
        vecs[1] = '{48'd0, ONES, 104'd0};
        vecs[2] = '{48'd12345, 48'd1000, 104'd12345000};
        vecs[3] = '{48'h8000_0000_0000, 48'd2, 104'h1_0000_0000_0000};
        vecs[4] = '{ONES, ONES, 104'hFFFF_FFFF_FFFE_0000_0000_0001};
        vecs[5] = '{48'h1_0000_0000, 48'h1_0000_0000, 104'h1_0000_0000_0000_0000};
        bp_exp  = '{104'd10, 104'd20, 104'd30, 104'd40};

        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        #2;
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_in_ready",  128'(bus.in_ready),  128'(1));
        check("rst_err",       128'(bus.err),       128'(0));
        check("rst_out_data",  128'(bus.out_data),  128'(0));
        check("rst_out_ovf",   128'(bus.out_ovf),   128'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Single-element frame latency: out_valid rises exactly at edge k+LAT.
        send(48'd3, 48'd5, 1'b1, 1'b1);
        for (int j = 1; j <= LAT; j++) begin
            if (j > 1) begin @(posedge clk); #1; end
            if (j < LAT) check($sformatf("lat_early_%0d", j), 128'(bus.out_valid), 128'(0));
        end
        @(posedge clk); #1;
        check("lat_out_valid", 128'(bus.out_valid), 128'(1));
        expect_result("lat", 104'd15, 1'b0);
        check("lat_drained", 128'(bus.out_valid), 128'(0));

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].a, vecs[i].b, 1'b1, 1'b1);
            expect_result($sformatf("vec%0d", i), vecs[i].exp, 1'b0);
        end

        s0 = n_stalls;
        send(48'd1, 48'd2, 1'b1, 1'b0);
        send(48'd3, 48'd4, 1'b0, 1'b0);
        send(48'd5, 48'd6, 1'b0, 1'b0);
        send(48'd7, 48'd8, 1'b0, 1'b1);
        check("frame4_stalls", 128'(n_stalls - s0), 128'(0));
        expect_result("frame4", 104'd100, 1'b0);
        check("frame4_err", 128'(bus.err), 128'(0));

        // 257 * (2^48-1)^2 wraps past 2^104.
        s0 = n_stalls;
        for (int i = 0; i < 257; i++) begin
            send(ONES, ONES, (i == 0), (i == 256));
        end
        check("ovf_stalls", 128'(n_stalls - s0), 128'(0));
        expect_result("ovf257", 104'h00_FFFF_FFFF_FDFE_0000_0000_0101, 1'b1);

        // Backpressure: stream single-element frames with out_ready low.
        acc_n = 0;
        bus.in_first = 1'b1;
        bus.in_last  = 1'b1;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            a  = WIDTH'(acc_n + 1);
            b  = 48'd10;
            hs = bus.in_ready;
            @(posedge clk); #1;
            if (hs) acc_n++;
        end
        bus.in_valid = 1'b0;
        check("bp_accepted",  128'(acc_n),         128'(4));
        check("bp_in_ready",  128'(bus.in_ready),  128'(0));
        check("bp_out_valid", 128'(bus.out_valid), 128'(1));
        for (int i = 0; i < 4; i++) begin
            expect_result($sformatf("bp%0d", i), bp_exp[i], 1'b0);
        end
        check("bp_empty",     128'(bus.out_valid), 128'(0));
        check("bp_ready_back", 128'(bus.in_ready), 128'(1));

        // Stray first mid-frame discards the partial sum.
        send(48'd2, 48'd2, 1'b1, 1'b0);
        send(48'd3, 48'd3, 1'b1, 1'b1);
        expect_result("proto", 104'd9, 1'b0);
        check("proto_err", 128'(bus.err), 128'(1));
        repeat (6) @(posedge clk);
        #1;
        check("proto_single", 128'(bus.out_valid), 128'(0));

        // Asynchronous reset with two products in flight.
        send(48'd2, 48'd3, 1'b1, 1'b0);
        send(48'd4, 48'd5, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        check("mrst_out_valid", 128'(bus.out_valid), 128'(0));
        check("mrst_err",       128'(bus.err),       128'(0));
        check("mrst_in_ready",  128'(bus.in_ready),  128'(1));
        check("mrst_out_data",  128'(bus.out_data),  128'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("mrst_no_stale", 128'(bus.out_valid), 128'(0));
        send(48'd6, 48'd7, 1'b1, 1'b0);
        send(48'd1, 48'd1, 1'b0, 1'b1);
        expect_result("mrst_next", 104'd43, 1'b0);
        check("mrst_next_err", 128'(bus.err), 128'(0));

        // Missing first in IDLE is flagged and treated as a frame start.
        send(48'd4, 48'd4, 1'b0, 1'b1);
        expect_result("nofirst", 104'd16, 1'b0);
        check("nofirst_err", 128'(bus.err), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
